spike_weight_fetch: RTL and testbench

SPIKE_WEIGHT_FETCH -- requirements
Module: spike_weight_fetch

---
 rtl/spike_weight_fetch.sv | 141 ++++++++++++++
 tb/tb_spike_weight_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_weight_fetch.sv
// Spike-group weight fetcher: walks the 4-spike groups of a packet, reads one weight word per group
// and hands spike/weight pairs to the MAC stage. Optional zero-group skipping: SPIKE_WEIGHT_FETCH_ZERO_SKIP_EN.
module spike_weight_fetch #(
    parameter int NUM_GROUPS = 4,
    parameter int ADDR_W     = 8,
    localparam int SW        = 4 * NUM_GROUPS,
    localparam int GW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [SW-1:0]     spike_vec,
    input  logic [ADDR_W-1:0] row_base,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    output logic [3:0]        spike_out,
    output logic [127:0]      weight_out,
    output logic              out_valid,
    output logic              last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     spikes_q, spikes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [GW-1:0]     g_q, g_d;
    logic [3:0]        spike_q, spike_d;
    logic [127:0]      weight_q, weight_d;
    logic              out_valid_q, out_valid_d;
    logic              last_q, last_d;

    logic              first_found, next_found;
    logic [GW-1:0]     first_idx, next_idx;

`ifdef SPIKE_WEIGHT_FETCH_ZERO_SKIP_EN
    // Lowest group index >= start whose slice is non-zero; MSB flags whether one exists.
    function automatic logic [GW:0] find_nonzero(input logic [SW-1:0] vec, input int start);
        logic [GW:0] res;
        res = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (i >= start && vec[4*i +: 4] != 4'd0) begin
                res = {1'b1, GW'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {first_found, first_idx} = find_nonzero(spike_vec, 0);
        {next_found, next_idx}   = find_nonzero(spikes_q, int'(g_q) + 1);
    end
`else
    assign first_found = 1'b1;
    assign first_idx   = '0;
    assign next_found  = (g_q != GW'(NUM_GROUPS - 1));
    assign next_idx    = g_q + 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            spikes_q    <= '0;
            base_q      <= '0;
            g_q         <= '0;
            spike_q     <= '0;
            weight_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            spikes_q    <= spikes_d;
            base_q      <= base_d;
            g_q         <= g_d;
            spike_q     <= spike_d;
            weight_q    <= weight_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        spikes_d    = spikes_q;
        base_d      = base_q;
        g_d         = g_q;
        spike_d     = spike_q;
        weight_d    = weight_q;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;

        case (state_q)
            IDLE: begin
                // An all-zero packet (skip build) is consumed here without leaving IDLE.
                if (in_valid) begin
                    spikes_d = spike_vec;
                    base_d   = row_base;
                    g_d      = first_idx;
                    if (first_found) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'(g_q);
                state_d  = CAPT;
            end
            CAPT: begin
                weight_d    = mem_rdata;
                spike_d     = spikes_q[{g_q, 2'b00} +: 4];
                out_valid_d = 1'b1;
                if (next_found) begin
                    g_d     = next_idx;
                    state_d = READ;
                end else begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign spike_out  = spike_q;
    assign weight_out = weight_q;
    assign out_valid  = out_valid_q;
    assign last       = last_q;

endmodule

// File: tb/tb_spike_weight_fetch.sv
// Self-checking bench for spike_weight_fetch: streams of packets are checked against a
// cycle-level reference built from the packet contents and a weight-memory model.
module tb_spike_weight_fetch;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [15:0]  spike_vec;
    logic [7:0]   row_base;
    logic         in_valid;
    logic         in_ready;
    logic         mem_en;
    logic [7:0]   mem_addr;
    logic [127:0] mem_rdata = '0;
    logic [3:0]   spike_out;
    logic [127:0] weight_out;
    logic         out_valid;
    logic         last;

    spike_weight_fetch #(.NUM_GROUPS(4), .ADDR_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .spike_vec(spike_vec), .row_base(row_base),
        .in_valid(in_valid), .in_ready(in_ready), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .spike_out(spike_out), .weight_out(weight_out),
        .out_valid(out_valid), .last(last)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { int cyc; logic [7:0] addr; } mem_ev_t;
    typedef struct packed { int cyc; logic [3:0] spk; logic [127:0] w; logic last; } out_ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] mem [256];
    mem_ev_t obs_mem[$], exp_mem[$];
    out_ev_t obs_out[$], exp_out[$];
    int      obs_acc[$], exp_acc[$];
    logic [15:0] stim_vec[$];
    logic [7:0]  stim_base[$];

    // Weight memory: one-cycle read latency.
    always @(posedge CLK) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        mem_ev_t me;
        out_ev_t oe;
        if (RESET_N) begin
            if (mem_en) begin
                me.cyc = cyc; me.addr = mem_addr;
                obs_mem.push_back(me);
            end
            if (out_valid) begin
                oe.cyc = cyc; oe.spk = spike_out; oe.w = weight_out; oe.last = last;
                obs_out.push_back(oe);
            end
            if (in_valid && in_ready) obs_acc.push_back(cyc);
        end
    end

    task automatic clear_obs();
        obs_mem.delete(); obs_out.delete(); obs_acc.delete();
    endtask

    // Reference: each accepted packet reads its issued groups two cycles apart; offers are
    // held continuously, so the next packet is taken in the cycle its predecessor's last pulses.
    task automatic build_model(input int n0);
        int t;
        int grp[$];
        mem_ev_t me;
        out_ev_t oe;
        logic [15:0] v;
        logic [7:0] a;
        t = n0;
        exp_mem.delete(); exp_out.delete(); exp_acc.delete();
        for (int i = 0; i < stim_vec.size(); i++) begin
            v = stim_vec[i];
            grp.delete();
            for (int k = 0; k < 4; k++) begin
`ifdef SPIKE_WEIGHT_FETCH_ZERO_SKIP_EN
                if (v[4*k +: 4] != 4'd0) grp.push_back(k);
`else
                grp.push_back(k);
`endif
            end
            exp_acc.push_back(t);
            for (int j = 0; j < grp.size(); j++) begin
                a = stim_base[i] + 8'(grp[j]);
                me.cyc = t + 1 + 2*j; me.addr = a;
                exp_mem.push_back(me);
                oe.cyc = t + 3 + 2*j; oe.spk = v[4*grp[j] +: 4]; oe.w = mem[a];
                oe.last = (j == grp.size() - 1);
                exp_out.push_back(oe);
            end
            t = (grp.size() > 0) ? t + 2*grp.size() + 1 : t + 1;
        end
    endtask

    // Offers the stimulus queue back to back with in_valid held, then drains.
    task automatic run_stream(output int n0);
        bit ok;
        clear_obs();
        n0 = -1;
        @(posedge CLK); #1;
        for (int i = 0; i < stim_vec.size(); i++) begin
            in_valid = 1'b1; spike_vec = stim_vec[i]; row_base = stim_base[i];
            ok = 1'b0;
            for (int k = 0; k < 60 && !ok; k++) begin
                @(negedge CLK);
                if (n0 < 0) n0 = cyc;
                if (in_ready) ok = 1'b1;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout packet %0d in_ready=%b required 1", i, in_ready);
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0; spike_vec = 16'($urandom); row_base = 8'($urandom);
        repeat (14) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_obs();
        RESET_N = 1'b0; in_valid = 1'b0; spike_vec = '0; row_base = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b required 0", mem_en); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got %h required 00", mem_addr); end
        checks++; if (spike_out !== 4'h0) begin errors++; $display("FAIL rst_spike_out got %h required 0", spike_out); end
        checks++; if (weight_out !== 128'h0) begin errors++; $display("FAIL rst_weight_out got %h required 0", weight_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_last got %b required 0", last); end
        @(negedge CLK); RESET_N = 1'b1;
        spike_vec = 16'($urandom); row_base = 8'($urandom);
        repeat (4) @(posedge CLK);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b required 1", in_ready); end
        checks++;
        if (obs_mem.size() != 0 || obs_out.size() != 0) begin
            errors++;
            $display("FAIL post_rst_idle got mem_reads=%0d outs=%0d required 0 0", obs_mem.size(), obs_out.size());
        end
    endtask

    task automatic test_directed();
        int n0;
        string tag;
        for (int a = 0; a < 256; a++) mem[a] = {4{32'(a)}};
        for (int s = 0; s < 5; s++) begin
            stim_vec.delete(); stim_base.delete();
            case (s)
                0: begin stim_vec.push_back(16'hFFFF); stim_base.push_back(8'h10); end
                1: begin stim_vec.push_back(16'h1111); stim_base.push_back(8'hFE); end
                2: begin stim_vec.push_back(16'hFFFF); stim_base.push_back(8'h40);
                         stim_vec.push_back(16'h2222); stim_base.push_back(8'h50); end
                3: begin stim_vec.push_back(16'h0300); stim_base.push_back(8'h00); end
                default: begin
                    stim_vec.push_back(16'h0000); stim_base.push_back(8'h00);
                    stim_vec.push_back(16'h0300); stim_base.push_back(8'h04);
                    stim_vec.push_back(16'h000F); stim_base.push_back(8'h08);
                end
            endcase
            tag = $sformatf("dir%0d", s);
            run_stream(n0);
            build_model(n0);
            checks++;
            if (obs_acc.size() != exp_acc.size()) begin errors++; $display("FAIL %s accept_count got %0d required %0d", tag, obs_acc.size(), exp_acc.size()); end
            for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
                checks++;
                if (obs_acc[i] !== exp_acc[i]) begin errors++; $display("FAIL %s accept[%0d] got cyc=%0d required cyc=%0d", tag, i, obs_acc[i], exp_acc[i]); end
            end
            checks++;
            if (obs_mem.size() != exp_mem.size()) begin errors++; $display("FAIL %s read_count got %0d required %0d", tag, obs_mem.size(), exp_mem.size()); end
            for (int i = 0; i < exp_mem.size() && i < obs_mem.size(); i++) begin
                checks++;
                if (obs_mem[i] !== exp_mem[i]) begin
                    errors++;
                    $display("FAIL %s read[%0d] got cyc=%0d addr=%h required cyc=%0d addr=%h", tag, i,
                             obs_mem[i].cyc, obs_mem[i].addr, exp_mem[i].cyc, exp_mem[i].addr);
                end
            end
            checks++;
            if (obs_out.size() != exp_out.size()) begin errors++; $display("FAIL %s out_count got %0d required %0d", tag, obs_out.size(), exp_out.size()); end
            for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
                checks++;
                if (obs_out[i] !== exp_out[i]) begin
                    errors++;
                    $display("FAIL %s out[%0d] got cyc=%0d spk=%h last=%b w=%h required cyc=%0d spk=%h last=%b w=%h", tag, i,
                             obs_out[i].cyc, obs_out[i].spk, obs_out[i].last, obs_out[i].w,
                             exp_out[i].cyc, exp_out[i].spk, exp_out[i].last, exp_out[i].w);
                end
            end
            if (exp_out.size() > 0) begin
                checks++;
                if (spike_out !== exp_out[exp_out.size()-1].spk || weight_out !== exp_out[exp_out.size()-1].w ||
                    out_valid !== 1'b0 || last !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold got spk=%h w=%h ov=%b last=%b required spk=%h w=%h ov=0 last=0", tag,
                             spike_out, weight_out, out_valid, last,
                             exp_out[exp_out.size()-1].spk, exp_out[exp_out.size()-1].w);
                end
            end
            $display("scenario %s packets=%0d reads=%0d outs=%0d", tag, stim_vec.size(), obs_mem.size(), obs_out.size());
        end
    endtask

    task automatic test_random();
        int n0;
        int npk;
        logic [15:0] v;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
            stim_vec.delete(); stim_base.delete();
            npk = $urandom_range(1, 4);
            for (int p = 0; p < npk; p++) begin
                v = 16'($urandom);
                for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
                stim_vec.push_back(v); stim_base.push_back(8'($urandom));
            end
            run_stream(n0);
            build_model(n0);
            checks++;
            if (obs_acc.size() != exp_acc.size()) begin errors++; $display("FAIL rnd%0d accept_count got %0d required %0d", r, obs_acc.size(), exp_acc.size()); end
            for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
                checks++;
                if (obs_acc[i] !== exp_acc[i]) begin errors++; $display("FAIL rnd%0d accept[%0d] got cyc=%0d required cyc=%0d", r, i, obs_acc[i], exp_acc[i]); end
            end
            checks++;
            if (obs_mem.size() != exp_mem.size()) begin errors++; $display("FAIL rnd%0d read_count got %0d required %0d", r, obs_mem.size(), exp_mem.size()); end
            for (int i = 0; i < exp_mem.size() && i < obs_mem.size(); i++) begin
                checks++;
                if (obs_mem[i] !== exp_mem[i]) begin
                    errors++;
                    $display("FAIL rnd%0d read[%0d] got cyc=%0d addr=%h required cyc=%0d addr=%h", r, i,
                             obs_mem[i].cyc, obs_mem[i].addr, exp_mem[i].cyc, exp_mem[i].addr);
                end
            end
            checks++;
            if (obs_out.size() != exp_out.size()) begin errors++; $display("FAIL rnd%0d out_count got %0d required %0d", r, obs_out.size(), exp_out.size()); end
            for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
                checks++;
                if (obs_out[i] !== exp_out[i]) begin
                    errors++;
                    $display("FAIL rnd%0d out[%0d] got cyc=%0d spk=%h last=%b w=%h required cyc=%0d spk=%h last=%b w=%h", r, i,
                             obs_out[i].cyc, obs_out[i].spk, obs_out[i].last, obs_out[i].w,
                             exp_out[i].cyc, exp_out[i].spk, exp_out[i].last, exp_out[i].w);
                end
            end
            $display("random stream %0d packets=%0d reads=%0d outs=%0d", r, npk, obs_mem.size(), obs_out.size());
        end
    endtask

    task automatic test_reset_midway();
        bit ok;
        for (int a = 0; a < 256; a++) mem[a] = {4{32'(a)}};
        clear_obs();
        @(posedge CLK); #1;
        in_valid = 1'b1; spike_vec = 16'hFFFF; row_base = 8'h20;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin @(negedge CLK); if (in_ready) ok = 1'b1; end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin @(negedge CLK); #1; if (obs_out.size() >= 2) ok = 1'b1; end
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_second_out got outs=%0d required 2", obs_out.size()); end
        // Cycle of the 2nd pulse is also the 3rd group's read cycle.
        checks++;
        if (mem_en !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got mem_en=%b out_valid=%b required 1 1", mem_en, out_valid);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mem_en !== 1'b0 || in_ready !== 1'b1 || last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got out_valid=%b mem_en=%b in_ready=%b last=%b required 0 0 1 0", out_valid, mem_en, in_ready, last);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK); RESET_N = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        checks++;
        if (obs_out.size() != 2 || obs_mem.size() != 3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_discard got outs=%0d reads=%0d in_ready=%b required 2 3 1", obs_out.size(), obs_mem.size(), in_ready);
        end
        $display("reset-midway outs=%0d reads=%0d", obs_out.size(), obs_mem.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
